// File: rtl/check_pkg.sv
// Shared types and default parameters for the check result collector.
package check_pkg;

  localparam int N_DEFAULT       = 16;
  localparam int ID_W_DEFAULT    = 8;
  localparam int TIMEOUT_DEFAULT = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic                    pass;
    logic                    timeout;
    logic [N_DEFAULT-1:0]    check_count;
    logic [N_DEFAULT-1:0]    fail_count;
    logic [ID_W_DEFAULT-1:0] first_fail_id;
  } verdict_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/check_monitor.sv
// Collects pass/fail check results for one session and produces a registered
// PASS/FAIL/TIMEOUT verdict, guarded by an idle watchdog.
module check_monitor
  import check_pkg::*;
#(
  parameter int N              = N_DEFAULT,
  parameter int ID_W           = ID_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            finish,
  input  logic            add_valid,
  output logic            add_ready,
  input  logic            add_cond,
  input  logic [ID_W-1:0] add_id,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [N-1:0]    check_count,
  output logic [N-1:0]    fail_count,
  output logic [ID_W-1:0] first_fail_id
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd;
  logic            enter_run;
  logic            hs;
  logic            fail_hs;
  logic            final_pass;

  assign hs      = add_valid & add_ready;
  assign fail_hs = hs & ~add_cond;
  assign add_ready = busy;

  // Verdict must include a check accepted in the same cycle as finish.
  assign final_pass = (fail_count == '0) && !fail_hs && ((check_count != '0) || hs);

  always_comb begin
    state_next = state;
    enter_run  = 1'b0;
    case (state)
      RUN: begin
        if (finish) begin
          state_next = DONE;
        end else if (!hs && (wd == WD_LIMIT)) begin
          state_next = TOUT;
        end
      end
      default: begin
        if (start) begin
          state_next = RUN;
          enter_run  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      first_fail_id <= '0;
      wd            <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE) || (state_next == TOUT);
      if (enter_run) begin
        pass          <= 1'b0;
        timeout       <= 1'b0;
        first_fail_id <= '0;
        wd            <= '0;
      end else if (state == RUN) begin
        if (hs) begin
          wd <= '0;
        end else if (wd != WD_LIMIT) begin
          wd <= wd + WD_W'(1);
        end
        if (fail_hs && (fail_count == '0)) begin
          first_fail_id <= add_id;
        end
        if (state_next == DONE) begin
          pass <= final_pass;
        end else if (state_next == TOUT) begin
          pass    <= 1'b0;
          timeout <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(N)) u_check_count (
    .clk (clk),
    .rst (rst),
    .clr (enter_run),
    .inc (hs),
    .q   (check_count)
  );

  sat_counter #(.W(N)) u_fail_count (
    .clk (clk),
    .rst (rst),
    .clr (enter_run),
    .inc (fail_hs),
    .q   (fail_count)
  );

endmodule
